// File: rtl/sat_pkg.sv
// Shared definitions for the clause control stage: FSM states, clause
// status encoding and the lit-chain free-literal count encoding.
package sat_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EVAL,
        S_IMPLY,
        S_IDRIVE,
        S_CDRIVE,
        S_CAPTURE,
        S_CONFL
    } state_t;

    localparam logic [1:0] ST_UNDEF = 2'b00;
    localparam logic [1:0] ST_SAT   = 2'b01;
    localparam logic [1:0] ST_UNIT  = 2'b10;
    localparam logic [1:0] ST_CONFL = 2'b11;

    localparam logic [1:0] FLC_ZERO = 2'd0;
    localparam logic [1:0] FLC_ONE  = 2'd1;
    localparam logic [1:0] FLC_MANY = 2'd2;

    // Satisfied wins over everything; a count of 3 behaves like "many".
    function automatic logic [1:0] classify(input logic sat, input logic [1:0] flc);
        logic [1:0] result;
        result = ST_UNDEF;
        if (sat) begin
            result = ST_SAT;
        end else begin
            case (flc)
                FLC_ZERO: result = ST_CONFL;
                FLC_ONE:  result = ST_UNIT;
                default:  result = ST_UNDEF;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/clause_ctrl.sv
// Per-clause control stage behind a lit-cell chain: waits for the chain to
// settle after a write, classifies the clause, and then either requests an
// implication or collects and hands off the conflict clause.
module clause_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_LITS   = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [1:0]          freelitcnt_i,
    input  logic                clausesat_i,
    input  logic [NUM_LITS-1:0] cclause_i,
    output logic                imp_drv_o,
    output logic                cclause_drv_o,
    output logic                imp_valid_o,
    input  logic                imp_ready_i,
    output logic                confl_valid_o,
    input  logic                confl_ready_i,
    output logic [NUM_LITS-1:0] confl_clause_o,
    output logic [1:0]          status_o,
    output logic                busy_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [3:0]          settle_cnt_q, settle_cnt_d;
    logic                pending_q, pending_d;
    logic [1:0]          status_q, status_d;
    logic                imp_drv_q, imp_drv_d;
    logic                cclause_drv_q, cclause_drv_d;
    logic                imp_valid_q, imp_valid_d;
    logic                confl_valid_q, confl_valid_d;
    logic [NUM_LITS-1:0] confl_clause_q, confl_clause_d;
    logic [1:0]          eval_class;

    assign eval_class = classify(clausesat_i, freelitcnt_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i || pending_q) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                case (eval_class)
                    ST_UNIT:  state_d = S_IMPLY;
                    ST_CONFL: state_d = S_CDRIVE;
                    default:  state_d = S_IDLE;
                endcase
            end
            S_IMPLY: begin
                if (imp_ready_i) begin
                    state_d = S_IDRIVE;
                end
            end
            S_IDRIVE:  state_d = S_IDLE;
            S_CDRIVE:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_CONFL;
            S_CONFL: begin
                if (confl_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    // Output and datapath next values; outputs are decoded from the next
    // state so that the registered versions line up with the state itself.
    always_comb begin
        settle_cnt_d   = settle_cnt_q;
        pending_d      = pending_q;
        status_d       = status_q;
        confl_clause_d = confl_clause_q;

        if (state_q == S_IDLE && state_d == S_SETTLE) begin
            settle_cnt_d = SETTLE_LOAD;
        end else if (state_q == S_SETTLE && settle_cnt_q != 4'd0) begin
            settle_cnt_d = settle_cnt_q - 4'd1;
        end

        if (state_q != S_IDLE && start_i) begin
            pending_d = 1'b1;
        end
        if (state_q == S_IDLE && state_d == S_SETTLE) begin
            pending_d = 1'b0;
        end
        if (abort_i) begin
            pending_d = 1'b0;
        end

        if (state_q == S_EVAL && !abort_i) begin
            status_d = eval_class;
        end

        if (state_q == S_CAPTURE && !abort_i) begin
            confl_clause_d = cclause_i;
        end

        imp_valid_d   = (state_d == S_IMPLY);
        imp_drv_d     = (state_d == S_IDRIVE);
        cclause_drv_d = (state_d == S_CDRIVE) || (state_d == S_CAPTURE);
        confl_valid_d = (state_d == S_CONFL);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_q   <= 4'd0;
            pending_q      <= 1'b0;
            status_q       <= ST_UNDEF;
            confl_clause_q <= '0;
            imp_valid_q    <= 1'b0;
            imp_drv_q      <= 1'b0;
            cclause_drv_q  <= 1'b0;
            confl_valid_q  <= 1'b0;
        end else begin
            settle_cnt_q   <= settle_cnt_d;
            pending_q      <= pending_d;
            status_q       <= status_d;
            confl_clause_q <= confl_clause_d;
            imp_valid_q    <= imp_valid_d;
            imp_drv_q      <= imp_drv_d;
            cclause_drv_q  <= cclause_drv_d;
            confl_valid_q  <= confl_valid_d;
        end
    end

    assign imp_drv_o      = imp_drv_q;
    assign cclause_drv_o  = cclause_drv_q;
    assign imp_valid_o    = imp_valid_q;
    assign confl_valid_o  = confl_valid_q;
    assign confl_clause_o = confl_clause_q;
    assign status_o       = status_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_clause_ctrl.sv
// Bench for clause_ctrl: two instances (settle 1 and settle 3) share one
// stimulus stream; a timestamp-based model predicts every output each cycle
// and directed literal checks pin the key scenarios.
module tb_clause_ctrl;

    localparam int M_EVAL  = 0;
    localparam int M_UNIT  = 1;
    localparam int M_PULSE = 2;
    localparam int M_CONFL = 3;

    typedef struct {
        bit         active;
        int         mode;
        int         eval_edge;
        bit         pending;
        logic [1:0] status;
        logic [1:0] clause;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [1:0] freelitcnt_i = 2'd2;
    logic       clausesat_i = 1'b0;
    logic [1:0] cclause_i = 2'b00;
    logic       imp_ready_i = 1'b0;
    logic       confl_ready_i = 1'b0;

    logic       imp_drv1, cdrv1, ivalid1, cvalid1, busy1;
    logic [1:0] clause1, status1;
    logic       imp_drv3, cdrv3, ivalid3, cvalid3, busy3;
    logic [1:0] clause3, status3;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    bit model_live = 1'b0;
    model_t m1, m3;

    clause_ctrl #(.NUM_LITS(2), .SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .freelitcnt_i(freelitcnt_i), .clausesat_i(clausesat_i), .cclause_i(cclause_i),
        .imp_drv_o(imp_drv1), .cclause_drv_o(cdrv1), .imp_valid_o(ivalid1),
        .imp_ready_i(imp_ready_i), .confl_valid_o(cvalid1), .confl_ready_i(confl_ready_i),
        .confl_clause_o(clause1), .status_o(status1), .busy_o(busy1)
    );

    clause_ctrl #(.NUM_LITS(2), .SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .freelitcnt_i(freelitcnt_i), .clausesat_i(clausesat_i), .cclause_i(cclause_i),
        .imp_drv_o(imp_drv3), .cclause_drv_o(cdrv3), .imp_valid_o(ivalid3),
        .imp_ready_i(imp_ready_i), .confl_valid_o(cvalid3), .confl_ready_i(confl_ready_i),
        .confl_clause_o(clause3), .status_o(status3), .busy_o(busy3)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    function automatic model_t model_next(input model_t m_in, input int s, input int e);
        model_t m;
        bit was_idle;
        m = m_in;
        was_idle = !m.active;
        if (rst) begin
            m.active = 0; m.mode = M_EVAL; m.eval_edge = 0; m.pending = 0;
            m.status = 2'b00; m.clause = 2'b00;
        end else if (abort_i) begin
            m.active = 0;
            m.pending = 0;
        end else begin
            if (start_i && !was_idle) m.pending = 1;
            if (!was_idle) begin
                case (m.mode)
                    M_EVAL: begin
                        if (e == m.eval_edge) begin
                            if (clausesat_i) begin
                                m.status = 2'b01; m.active = 0;
                            end else if (freelitcnt_i == 2'd0) begin
                                m.status = 2'b11; m.mode = M_CONFL;
                            end else if (freelitcnt_i == 2'd1) begin
                                m.status = 2'b10; m.mode = M_UNIT;
                            end else begin
                                m.status = 2'b00; m.active = 0;
                            end
                        end
                    end
                    M_UNIT:  if (imp_ready_i) m.mode = M_PULSE;
                    M_PULSE: m.active = 0;
                    default: begin
                        if (e == m.eval_edge + 2) m.clause = cclause_i;
                        else if (e > m.eval_edge + 2 && confl_ready_i) m.active = 0;
                    end
                endcase
            end else if (start_i || m.pending) begin
                m.active = 1; m.mode = M_EVAL; m.eval_edge = e + s + 1; m.pending = 0;
            end
        end
        return m;
    endfunction

    // Model update on every rising edge.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        m1 = model_next(m1, 1, edge_n);
        m3 = model_next(m3, 3, edge_n);
        model_live = 1'b1;
    end

    // Compare both instances against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (model_live) begin
            check_output("d1.busy",   {7'd0, busy1},   {7'd0, m1.active});
            check_output("d1.status", {6'd0, status1}, {6'd0, m1.status});
            check_output("d1.clause", {6'd0, clause1}, {6'd0, m1.clause});
            check_output("d1.ivalid", {7'd0, ivalid1}, {7'd0, m1.active && m1.mode == M_UNIT});
            check_output("d1.idrv",   {7'd0, imp_drv1}, {7'd0, m1.active && m1.mode == M_PULSE});
            check_output("d1.cdrv",   {7'd0, cdrv1},
                         {7'd0, m1.active && m1.mode == M_CONFL && edge_n < m1.eval_edge + 2});
            check_output("d1.cvalid", {7'd0, cvalid1},
                         {7'd0, m1.active && m1.mode == M_CONFL && edge_n >= m1.eval_edge + 2});
            check_output("d3.busy",   {7'd0, busy3},   {7'd0, m3.active});
            check_output("d3.status", {6'd0, status3}, {6'd0, m3.status});
            check_output("d3.clause", {6'd0, clause3}, {6'd0, m3.clause});
            check_output("d3.ivalid", {7'd0, ivalid3}, {7'd0, m3.active && m3.mode == M_UNIT});
            check_output("d3.idrv",   {7'd0, imp_drv3}, {7'd0, m3.active && m3.mode == M_PULSE});
            check_output("d3.cdrv",   {7'd0, cdrv3},
                         {7'd0, m3.active && m3.mode == M_CONFL && edge_n < m3.eval_edge + 2});
            check_output("d3.cvalid", {7'd0, cvalid3},
                         {7'd0, m3.active && m3.mode == M_CONFL && edge_n >= m3.eval_edge + 2});
        end
    end

    task automatic apply_stimulus(input logic st, input logic sat, input logic [1:0] cnt,
                                  input logic [1:0] ccl);
        start_i      = st;
        clausesat_i  = sat;
        freelitcnt_i = cnt;
        cclause_i    = ccl;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed scenarios; comments give the negedge index Nn after the
    // start pulse set at N0.
    initial begin
        tick(2);
        check_output("rst.status", {6'd0, status1}, 8'h00);
        check_output("rst.busy",   {7'd0, busy1},   8'h00);
        check_output("rst.clause", {6'd0, clause1}, 8'h00);
        rst = 1'b0;
        tick(1);

        // SAT: status 01 visible at N3, never any drive/valid.
        apply_stimulus(1'b1, 1'b1, 2'd2, 2'b00);
        tick(1); start_i = 1'b0;
        tick(1);
        check_output("sat.busy_mid",   {7'd0, busy1},   8'h01);
        check_output("sat.status_old", {6'd0, status1}, 8'h00);
        tick(1);
        check_output("sat.status", {6'd0, status1}, 8'h01);
        check_output("sat.busy",   {7'd0, busy1},   8'h00);
        tick(5);

        // UNIT: ready low for 4 valid cycles, then handshake.
        apply_stimulus(1'b1, 1'b0, 2'd1, 2'b00);
        imp_ready_i = 1'b0;
        tick(1); start_i = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            check_output("unit.ivalid", {7'd0, ivalid1}, 8'h01);
            check_output("unit.idrv0",  {7'd0, imp_drv1}, 8'h00);
            if (i < 3) tick(1);
        end
        check_output("unit.status", {6'd0, status1}, 8'h02);
        imp_ready_i = 1'b1;
        tick(1);
        check_output("unit.idrv",     {7'd0, imp_drv1}, 8'h01);
        check_output("unit.ivalid_dn", {7'd0, ivalid1}, 8'h00);
        imp_ready_i = 1'b0;
        tick(1);
        check_output("unit.idrv_dn", {7'd0, imp_drv1}, 8'h00);
        check_output("unit.busy_dn", {7'd0, busy1},    8'h00);
        tick(3);

        // CONFLICT: two drive cycles, clause 10 with valid, cleared by ready.
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'b10);
        tick(1); start_i = 1'b0;
        tick(1);
        check_output("confl.cdrv_pre", {7'd0, cdrv1}, 8'h00);
        tick(1);
        check_output("confl.cdrv_a", {7'd0, cdrv1}, 8'h01);
        tick(1);
        check_output("confl.cdrv_b", {7'd0, cdrv1}, 8'h01);
        check_output("confl.cvalid_pre", {7'd0, cvalid1}, 8'h00);
        tick(1);
        check_output("confl.cdrv_end", {7'd0, cdrv1},   8'h00);
        check_output("confl.cvalid",   {7'd0, cvalid1}, 8'h01);
        check_output("confl.clause",   {6'd0, clause1}, 8'h02);
        check_output("confl.status",   {6'd0, status1}, 8'h03);
        tick(2);
        confl_ready_i = 1'b1;
        tick(1);
        check_output("confl.cvalid_dn", {7'd0, cvalid1}, 8'h00);
        check_output("confl.busy_dn",   {7'd0, busy1},   8'h00);
        check_output("confl.clause_kept", {6'd0, clause1}, 8'h02);
        confl_ready_i = 1'b0;
        tick(3);

        // Pending: two starts during IMPLY merge into one re-evaluation.
        apply_stimulus(1'b1, 1'b0, 2'd1, 2'b00);
        tick(1); start_i = 1'b0;
        tick(2);
        check_output("pend.ivalid", {7'd0, ivalid1}, 8'h01);
        start_i = 1'b1;
        tick(1); start_i = 1'b0;
        tick(1); start_i = 1'b1;
        tick(1); start_i = 1'b0; imp_ready_i = 1'b1;
        tick(1);
        check_output("pend.idrv", {7'd0, imp_drv1}, 8'h01);
        imp_ready_i = 1'b0;
        tick(1);
        check_output("pend.idle", {7'd0, busy1}, 8'h00);
        tick(1);
        check_output("pend.resettle", {7'd0, busy1}, 8'h01);
        tick(2);
        check_output("pend.ivalid2", {7'd0, ivalid1}, 8'h01);
        imp_ready_i = 1'b1;
        tick(1);
        check_output("pend.idrv2", {7'd0, imp_drv1}, 8'h01);
        tick(2);
        imp_ready_i = 1'b0;
        check_output("pend.done", {7'd0, busy1}, 8'h00);
        tick(3);
        check_output("pend.single", {7'd0, busy1}, 8'h00);

        // Abort together with start while in CONFL.
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'b01);
        tick(1); start_i = 1'b0;
        tick(4);
        check_output("abort.cvalid_pre", {7'd0, cvalid1}, 8'h01);
        abort_i = 1'b1; start_i = 1'b1;
        tick(1);
        abort_i = 1'b0; start_i = 1'b0;
        check_output("abort.busy",   {7'd0, busy1},   8'h00);
        check_output("abort.cvalid", {7'd0, cvalid1}, 8'h00);
        tick(2);
        check_output("abort.no_reeval", {7'd0, busy1}, 8'h00);
        tick(3);

        // Reset during CDRIVE clears everything on the next cycle.
        apply_stimulus(1'b1, 1'b0, 2'd0, 2'b10);
        tick(1); start_i = 1'b0;
        tick(2);
        check_output("rstc.cdrv_pre", {7'd0, cdrv1}, 8'h01);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_output("rstc.cdrv",   {7'd0, cdrv1},   8'h00);
        check_output("rstc.busy",   {7'd0, busy1},   8'h00);
        check_output("rstc.status", {6'd0, status1}, 8'h00);
        check_output("rstc.clause", {6'd0, clause1}, 8'h00);
        tick(3);

        // SAT beats count 0, then count 3 gives UNDEF five cycles after start.
        apply_stimulus(1'b1, 1'b1, 2'd0, 2'b00);
        tick(1); start_i = 1'b0;
        tick(4);
        check_output("pre3.status", {6'd0, status3}, 8'h01);
        tick(2);
        apply_stimulus(1'b1, 1'b0, 2'd3, 2'b00);
        tick(1); start_i = 1'b0;
        tick(3);
        check_output("cnt3.status_old", {6'd0, status3}, 8'h01);
        tick(1);
        check_output("cnt3.status", {6'd0, status3}, 8'h00);
        check_output("cnt3.busy",   {7'd0, busy3},   8'h00);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clause_ctrl.md
# clause_ctrl

Per-clause control stage that sits directly downstream of a lit-cell chain such as `lit2`. It consumes the chain's final `freelitcnt` and `clausesat` after each variable write, classifies the clause as SAT, UNDEF, UNIT or CONFLICT, and drives the chain back:
- UNIT: a handshaked implication request upstream, then an `imp_drv` pulse.
- CONFLICT: a `cclause_drv` window that captures the per-literal conflict bits, then a handshaked conflict-clause hand-off to conflict analysis.

## Interface
Parameters:
- `NUM_LITS`, 2 — literals in the clause; width of `cclause_i` and `confl_clause_o`.
- `SETTLE_CYC`, 1 — cycles waited after a write before sampling the chain; legal range 1..15.

Ports. One clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  — clock.
- `rst`  in  1  — synchronous active-high reset.
- `start_i`  in  1  — variable values were written to the lit cells this cycle (same cycle as the chain's `wr_i`).
- `abort_i`  in  1  — backtrack/flush; cancels any activity.
- `freelitcnt_i`  in  2  — final free-literal count from the chain: 0, 1, 2 (= two or more); 3 is treated as 2.
- `clausesat_i`  in  1  — OR of the lit cells' `clausesat`.
- `cclause_i`  in  NUM_LITS  — lit cells' `cclause` bits; valid while `cclause_drv_o` is high.
- `imp_drv_o`  out  1  — one-cycle implication drive to the lit cells.
- `cclause_drv_o`  out  1  — requests the lit cells to present conflict bits.
- `imp_valid_o` / `imp_ready_i`  out / in  1 / 1  — implication request handshake to the base.
- `confl_valid_o` / `confl_ready_i`  out / in  1 / 1  — conflict hand-off handshake.
- `confl_clause_o`  out  NUM_LITS  — captured conflict bits.
- `status_o`  out  2  — 00 UNDEF, 01 SAT, 10 UNIT, 11 CONFLICT.
- `busy_o`  out  1  — state is not IDLE.

## Operation
- States: IDLE, SETTLE, EVAL, IMPLY, IDRIVE, CDRIVE, CAPTURE, CONFL.
- IDLE → SETTLE on `start_i` or `pending`. Entering SETTLE loads the settle counter with `SETTLE_CYC`-1 and clears `pending`.
- SETTLE: decrement the counter each cycle; go to EVAL when it is 0.
- EVAL samples the chain. Priority, highest first:
  - `clausesat_i` → `status_o`=SAT, go to IDLE.
  - count 0 → CONFLICT, go to CDRIVE.
  - count 1 → UNIT, go to IMPLY.
  - otherwise → UNDEF, go to IDLE.
- IMPLY: `imp_valid_o`=1 until `imp_ready_i`, then go to IDRIVE.
- IDRIVE: `imp_drv_o`=1 for one cycle, then go to IDLE.
- CDRIVE then CAPTURE: `cclause_drv_o`=1 in both. `confl_clause_o` registers `cclause_i` at the end of CAPTURE. Go to CONFL.
- CONFL: `confl_valid_o`=1 with `confl_clause_o` stable until `confl_ready_i`, then go to IDLE.
- `start_i` outside IDLE sets the single-deep `pending` flag; extra starts merge into it. `status_o` keeps its old value until the next EVAL.
- `abort_i` forces IDLE next cycle, clears `pending`, and drops any valid without a handshake. An abort is allowed to withdraw a request.
- If `abort_i` and `start_i` arrive in the same cycle, abort wins and the start is discarded.
- Reset values: all outputs 0, `status_o`=UNDEF, state IDLE, `pending` 0, `confl_clause_o` 0. Reset mid-handshake drops the request immediately.

## Timing
- All outputs are registered, apart from `busy_o`, which is decoded from the state register.
- `start_i` sampled at edge k: SETTLE for cycles k+1..k+S (S = `SETTLE_CYC`), EVAL in cycle k+S+1, `status_o` updated in cycle k+S+2.
- UNIT: `imp_valid_o` high from cycle k+S+2.
  - Handshake in cycle j gives `imp_drv_o`=1 in cycle j+1 only; `busy_o` drops in cycle j+2.
  - A same-cycle ready (j = k+S+2) is legal.
- CONFLICT: `cclause_drv_o` high in cycles k+S+2 and k+S+3; `confl_valid_o` high from cycle k+S+4.
- SAT/UNDEF: back to IDLE in cycle k+S+2. With `pending` set, SETTLE is re-entered in cycle k+S+3.
- Throughput: one evaluation per S+2 cycles when the chain is never UNIT or CONFLICT.

## Structure
- Shared package `sat_pkg`:
  - the state enum;
  - status encoding constants `ST_UNDEF`/`ST_SAT`/`ST_UNIT`/`ST_CONFL`;
  - the freelitcnt encoding (`FLC_ZERO`, `FLC_ONE`, `FLC_MANY`).
- Single flat module; no sub-module. The settle counter is a 4-bit down-counter.

## Test plan
- SAT: S=1, `start_i` at edge 0, `clausesat_i`=1, count=2 → `status_o`=01 in cycle 3; no drive or valid outputs ever assert; `busy_o` low in cycle 3.
- UNIT: count=1, sat=0, `imp_ready_i` held low for 4 cycles, then high → `imp_valid_o` stays high and stable; exactly one `imp_drv_o` pulse the cycle after the handshake.
- CONFLICT: count=0, `cclause_i`=2'b10 → `cclause_drv_o` high for 2 cycles; `confl_clause_o`=2'b10 with `confl_valid_o`; cleared after `confl_ready_i`.
- Pending: `start_i` during IMPLY (twice) → a single re-evaluation after IDRIVE, with SETTLE starting in the cycle after IDLE is entered.
- Abort/reset: `abort_i` and `start_i` together in CONFL → IDLE next cycle, valid dropped, no re-evaluation. `rst` during CDRIVE → all outputs 0 the next cycle.
- Count 3 with sat=0 and `SETTLE_CYC`=3 → UNDEF; `status_o` appears exactly 5 cycles after the `start_i` edge.
